// File: rtl/uart_tx_drain_if.sv
// FIFO read port and serial line bundle for uart_tx_drain.
// slave is the transmitter side; master is the FIFO/board side.
interface uart_tx_drain_if;
  logic [7:0] read_data_i;
  logic       read_valid_i;
  logic       fifo_empty_i;
  logic       read_enable_o;
  logic       tx_o;
  logic       busy_o;

  modport master (
    output read_data_i, read_valid_i, fifo_empty_i,
    input  read_enable_o, tx_o, busy_o
  );

  modport slave (
    input  read_data_i, read_valid_i, fifo_empty_i,
    output read_enable_o, tx_o, busy_o
  );
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter draining a registered-read FIFO, LSB-first 8N1.
// Define UART_TX_DRAIN_PARITY_EN for 8E1 frames (even parity bit before stop).
module uart_tx_drain #(
  parameter int unsigned CLOCKS_PER_BIT = 868
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  uart_tx_drain_if.slave bus
);

  localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
`ifdef UART_TX_DRAIN_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_n;
  logic [7:0]       shift, shift_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic             tx, tx_n;
  logic             busy, busy_n;
  logic             bit_end;
`ifdef UART_TX_DRAIN_PARITY_EN
  logic             par, par_n;
`endif

  assign bit_end           = (cnt == CNT_LAST);
  assign bus.read_enable_o = reset_ni && (state == IDLE) && !bus.fifo_empty_i;
  assign bus.tx_o          = tx;
  assign bus.busy_o        = busy;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      shift <= '0;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
`ifdef UART_TX_DRAIN_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      tx    <= tx_n;
      busy  <= busy_n;
`ifdef UART_TX_DRAIN_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  // tx is registered, so each transition loads the level of the bit being entered.
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    idx_n   = idx;
    tx_n    = tx;
`ifdef UART_TX_DRAIN_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        tx_n  = 1'b1;
        if (!bus.fifo_empty_i) state_n = FETCH;
      end
      FETCH: begin
        if (bus.read_valid_i) begin
          shift_n = bus.read_data_i;
`ifdef UART_TX_DRAIN_PARITY_EN
          par_n   = ^bus.read_data_i;
`endif
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b0;
          state_n = START;
        end else begin
          tx_n    = 1'b1;
          state_n = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          tx_n    = shift[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
`ifdef UART_TX_DRAIN_PARITY_EN
            tx_n    = par;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shift[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_TX_DRAIN_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          tx_n    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule
